// File: rtl/tuart_pkg.sv
// Shared Tiny-UART types and helpers for the transmitter and receiver.
// Latency: n/a (types/functions only).
// Backpressure: n/a.
package tuart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  function automatic int clks_per_bit(input int sys_clk_f, input int baud_rate);
    return sys_clk_f / baud_rate;
  endfunction

endpackage

// File: rtl/tuart_baud_tick.sv
// Bit-period counter: one-cycle tick at count CLKS_PER_BIT-1, then wraps.
// Latency: tick on the CLKS_PER_BIT-th cycle after clr drops.
// Backpressure: none; clr holds the count at zero.
module tuart_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk_i,
  input  logic rst_in,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_in || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/tuart_tx.sv
// Tiny-UART transmitter: sends an XFER_WIDTH word as 8N1-style frames, lowest word first.
// Latency: start bit one cycle after acceptance; done_o one cycle after the last stop bit.
// Backpressure: rdy_o high only in IDLE; valid_i while busy is dropped.
module tuart_tx
  import tuart_pkg::*;
#(
  parameter int XFER_WIDTH = 32,
  parameter int DATA_BITS  = 8,
  parameter int SYS_CLK_F  = 100_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic                  clk_i,
  input  logic                  rst_in,
  input  logic [XFER_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  rdy_o,
  output logic                  done_o,
  output logic                  tx_o
);

  localparam int CLKS_PER_BIT = clks_per_bit(SYS_CLK_F, BAUD_RATE);
  localparam int WORDS        = XFER_WIDTH / DATA_BITS;
  localparam int BW           = $clog2(DATA_BITS + 1);
  localparam int WW           = $clog2(WORDS + 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic [WW-1:0] LAST_WORD = WW'(WORDS - 1);

  if (XFER_WIDTH % DATA_BITS != 0) begin : g_bad_width
    $error("tuart_tx: XFER_WIDTH must be a multiple of DATA_BITS");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("tuart_tx: CLKS_PER_BIT must be at least 2");
  end

  tx_state_e             state_q, state_d;
  logic [XFER_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [WW-1:0]         word_cnt_q, word_cnt_d;
  logic                  tx_d, done_d, accept, tick;

  assign rdy_o  = (state_q == IDLE);
  assign accept = valid_i && rdy_o;

  // Timer is held at zero while idle so the first start bit gets a full period.
  tuart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i (clk_i),
    .rst_in(rst_in),
    .clr   (state_q == IDLE),
    .tick  (tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    done_d     = 1'b0;
    tx_d       = 1'b1;

    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d    = data_i;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          state_d    = START;
        end
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (word_cnt_q == LAST_WORD) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
            state_d    = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is derived from the next state so tx_o can be a plain flop.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      tx_o       <= 1'b1;
      done_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      tx_o       <= tx_d;
      done_o     <= done_d;
    end
  end

endmodule

// File: tb/tb_tuart_tx.sv
// Directed bench for tuart_tx at CLKS_PER_BIT=10, 8 data bits, 16-bit words.
// Expected line patterns are hand-written mid-bit vectors, index 0 = first bit on the line.
module tb_tuart_tx;

  logic        clk_i = 1'b0;
  logic        rst_in;
  logic [15:0] data_i;
  logic        valid_i;
  logic        rdy_o;
  logic        done_o;
  logic        tx_o;

  int n_asserts = 0;
  int n_fail    = 0;

  tuart_tx #(
    .XFER_WIDTH(16),
    .DATA_BITS (8),
    .SYS_CLK_F (10),
    .BAUD_RATE (1)
  ) dut (
    .clk_i  (clk_i),
    .rst_in (rst_in),
    .data_i (data_i),
    .valid_i(valid_i),
    .rdy_o  (rdy_o),
    .done_o (done_o),
    .tx_o   (tx_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a word for one edge; returns positioned at cycle 1 of the transfer.
  task automatic accept(input logic [15:0] d);
    data_i  = d;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  // Watches cycles 1..200 of a transfer and ends positioned on cycle 201 (done cycle).
  task automatic watch(input string tag, input logic [0:19] exp_bits, input bit busy_poke);
    logic [0:19] mid;
    int          wave_bad, edge_bad, done_cnt, rdy_bad;
    logic        prev;
    mid      = '0;
    wave_bad = 0;
    edge_bad = 0;
    done_cnt = 0;
    rdy_bad  = 0;
    prev     = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      if (tx_o !== exp_bits[(c-1)/10]) wave_bad++;
      if (tx_o !== prev && ((c - 1) % 10) != 0) edge_bad++;
      if ((c - 1) % 10 == 4) mid[(c-1)/10] = tx_o;
      if (done_o !== 1'b0) done_cnt++;
      if (rdy_o !== 1'b0) rdy_bad++;
      prev = tx_o;
      if (busy_poke && c == 30) begin
        data_i  = 16'hFFFF;
        valid_i = 1'b1;
      end
      if (busy_poke && c == 31) valid_i = 1'b0;
      tick();
    end
    if (done_o === 1'b1) done_cnt++;
    check({tag, " midbits"}, 32'(mid), 32'(exp_bits));
    check({tag, " wave"}, wave_bad, 0);
    check({tag, " bit_edges"}, edge_bad, 0);
    check({tag, " rdy_busy"}, rdy_bad, 0);
    check({tag, " done_count"}, done_cnt, 1);
    check({tag, " done_at_201"}, 32'(done_o), 1);
    check({tag, " rdy_at_201"}, 32'(rdy_o), 1);
    check({tag, " tx_at_201"}, 32'(tx_o), 1);
  endtask

  initial begin
    rst_in  = 1'b0;
    valid_i = 1'b1;
    data_i  = 16'hFFFF;

    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset tx", 32'(tx_o), 1);
      check("reset rdy", 32'(rdy_o), 1);
      check("reset done", 32'(done_o), 0);
    end
    rst_in  = 1'b1;
    valid_i = 1'b0;
    tick();
    check("post_reset idle tx", 32'(tx_o), 1);
    check("post_reset idle rdy", 32'(rdy_o), 1);

    // Single word 0xA55A: 0x5A frame then 0xA5 frame.
    accept(16'hA55A);
    watch("single", 20'b0010110101_0101001011, 1'b0);
    tick();
    check("single done_drops", 32'(done_o), 0);

    // Same word with a busy-time request for 0xFFFF, which must be dropped.
    accept(16'hA55A);
    watch("busy_ignore", 20'b0010110101_0101001011, 1'b1);
    tick();
    check("busy_ignore idle_after", 32'(rdy_o), 1);

    // Back-to-back: 0x8000, then 0x0001 accepted in the done cycle.
    accept(16'h8000);
    watch("b2b_first", 20'b0000000001_0000000011, 1'b0);
    accept(16'h0001);
    watch("b2b_second", 20'b0100000001_0000000001, 1'b0);
    tick();

    // Reset at cycle 55 of a transfer.
    accept(16'h1234);
    for (int c = 1; c < 55; c++) tick();
    check("midreset busy_before", 32'(rdy_o), 0);
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
    check("midreset tx", 32'(tx_o), 1);
    check("midreset rdy", 32'(rdy_o), 1);
    check("midreset done", 32'(done_o), 0);
    tick();
    accept(16'h00FF);
    watch("after_reset", 20'b0111111111_0000000001, 1'b0);
    tick();

    // Boundary data.
    accept(16'h0000);
    watch("zeros", 20'b0000000001_0000000001, 1'b0);
    tick();
    accept(16'hFFFF);
    watch("ones", 20'b0111111111_0111111111, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
